axi4_sram_slave: RTL and testbench

AXI4_SRAM_SLAVE -- requirements
Module: axi4_sram_slave

---
 rtl/axi4_sram_slave_if.sv | 40 ++++
 rtl/axi4_sram_slave.sv | 136 +++++++++++++
 tb/tb_axi4_sram_slave.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_sram_slave_if.sv
// Single-clock AXI4 bus bundle; the slave modport is the memory-responder view.
interface axi4_interface #(parameter int ID_W = 4);
  logic [31:0]     araddr;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            rvalid;
  logic            rready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic [ID_W-1:0] rid;
  logic            rlast;
  logic [31:0]     awaddr;
  logic            awvalid;
  logic            awready;
  logic [ID_W-1:0] awid;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wvalid;
  logic            wready;
  logic            wlast;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;

  modport slave (
    input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
    input  awaddr, awvalid, awid, awlen, awsize, awburst,
    input  wdata, wstrb, wvalid, wlast, bready,
    output arready, rvalid, rdata, rresp, rid, rlast,
    output awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/axi4_sram_slave.sv
// Single-beat AXI4 SRAM responder: response valid 1+delay edges after handshake, held until ready.
// Delay is LAT, or LFSR[3:0] & LAT when SRAM_RAND_DELAY_EN is defined; one outstanding txn per direction.
module axi4_sram_slave #(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 1024,
  parameter int          LAT   = 1
) (
  input logic          clk,
  input logic          rst,
  axi4_interface.slave sram
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH) * 32'd4;
  localparam logic [3:0]  LAT4 = 4'(LAT);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH];

  r_state_t    r_state;
  w_state_t    w_state;
  logic [3:0]  r_cnt, w_cnt, delay;
  logic [31:0] ar_off, aw_off;
  logic [AW-1:0] ar_idx;
  logic        ar_ok, w_ok;
  logic        rvalid_q, bvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q, bresp_q;
  logic        aw_hs;

`ifdef SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign delay = lfsr[3:0] & LAT4;
`else
  assign delay = LAT4;
`endif

  // Unsigned offset: addresses below BASE wrap to huge values and fail the range test.
  assign ar_off = sram.araddr - BASE;
  assign aw_off = sram.awaddr - BASE;

  // Address and data must arrive together; no acceptance while reset is held.
  assign aw_hs = (w_state == W_IDLE) && sram.awvalid && sram.wvalid && !rst;

  assign sram.arready = (r_state == R_IDLE);
  assign sram.awready = aw_hs;
  assign sram.wready  = aw_hs;
  assign sram.rvalid  = rvalid_q;
  assign sram.rdata   = rdata_q;
  assign sram.rresp   = rresp_q;
  assign sram.rlast   = 1'b1;
  assign sram.bvalid  = bvalid_q;
  assign sram.bresp   = bresp_q;

  always_ff @(posedge clk) begin
    if (aw_hs && (aw_off < SPAN)) begin
      for (int b = 0; b < 4; b++) begin
        if (sram.wstrb[b]) mem[aw_off[AW+1:2]][8*b +: 8] <= sram.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= R_IDLE;
      r_cnt    <= '0;
      ar_idx   <= '0;
      ar_ok    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      sram.rid <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (sram.arvalid) begin
          ar_idx   <= ar_off[AW+1:2];
          ar_ok    <= (ar_off < SPAN);
          sram.rid <= sram.arid;
          r_cnt    <= delay;
          r_state  <= R_WAIT;
        end
        // Memory is sampled here, after any same-cycle write has landed.
        R_WAIT: if (r_cnt == '0) begin
          rdata_q  <= ar_ok ? mem[ar_idx] : '0;
          rresp_q  <= ar_ok ? 2'b00 : 2'b10;
          rvalid_q <= 1'b1;
          r_state  <= R_RESP;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        R_RESP: if (sram.rready) begin
          rvalid_q <= 1'b0;
          r_state  <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state  <= W_IDLE;
      w_cnt    <= '0;
      w_ok     <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      sram.bid <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          w_ok     <= (aw_off < SPAN);
          sram.bid <= sram.awid;
          w_cnt    <= delay;
          w_state  <= W_WAIT;
        end
        W_WAIT: if (w_cnt == '0) begin
          bresp_q  <= w_ok ? 2'b00 : 2'b10;
          bvalid_q <= 1'b1;
          w_state  <= W_RESP;
        end else begin
          w_cnt <= w_cnt - 4'd1;
        end
        W_RESP: if (sram.bready) begin
          bvalid_q <= 1'b0;
          w_state  <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave (BASE 8000_0000, DEPTH 1024, LAT 1).
module tb_axi4_sram_slave;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_interface bus ();

  axi4_sram_slave #(.BASE(32'h8000_0000), .DEPTH(1024), .LAT(LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .sram (bus)
  );

  int tests = 0;
  int fails = 0;

  int          r_lat, b_lat;
  logic [31:0] r_dat;
  logic [1:0]  r_resp, b_resp;
  logic [3:0]  r_id, b_id;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int lat);
`ifdef SRAM_RAND_DELAY_EN
    check(tag, 32'(lat >= 1 && lat <= 1 + LAT), 32'd1);
`else
    check(tag, 32'(lat), 32'(1 + LAT));
`endif
  endtask

  // Presents requests at a negedge; returns at the negedge after the handshake edge.
  task automatic issue(input bit rd, input logic [31:0] ra, input logic [3:0] rid,
                       input bit wr, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [3:0] wid);
    int t;
    @(negedge clk);
    bus.arvalid = rd; bus.araddr = ra; bus.arid = rid;
    bus.awvalid = wr; bus.wvalid = wr; bus.awaddr = wa; bus.awid = wid;
    bus.wdata = wd; bus.wstrb = ws;
    #1;
    t = 0;
    while (((rd && !bus.arready) || (wr && !bus.awready)) && t < 50) begin
      @(negedge clk); #1; t++;
    end
    check("hs_timeout", 32'(t < 50), 32'd1);
    @(negedge clk);
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  // Latency counts edges from handshake to response valid.
  task automatic collect(input bit rd, input bit wr);
    bit rdone, wdone;
    rdone = !rd; wdone = !wr;
    r_lat = -1; b_lat = -1;
    for (int n = 0; n < 60 && !(rdone && wdone); n++) begin
      bus.rready = 1'b0; bus.bready = 1'b0;
      if (!rdone && bus.rvalid) begin
        r_lat = n; r_dat = bus.rdata; r_resp = bus.rresp; r_id = bus.rid;
        bus.rready = 1'b1; rdone = 1'b1;
      end
      if (!wdone && bus.bvalid) begin
        b_lat = n; b_resp = bus.bresp; b_id = bus.bid;
        bus.bready = 1'b1; wdone = 1'b1;
      end
      @(negedge clk);
    end
    bus.rready = 1'b0; bus.bready = 1'b0;
    check("resp_timeout", 32'(rdone && wdone), 32'd1);
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [3:0] id);
    issue(1'b0, 32'h0, 4'h0, 1'b1, a, d, s, id);
    collect(1'b0, 1'b1);
  endtask

  task automatic rd1(input logic [31:0] a, input logic [3:0] id);
    issue(1'b1, a, id, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
    collect(1'b1, 1'b0);
  endtask

  initial begin
    bit seen;
    int n;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.arid = '0;
    bus.arlen = 8'd7; bus.arsize = 3'd2; bus.arburst = 2'b01;
    bus.rready = 1'b0; bus.bready = 1'b0;
    bus.awaddr = '0; bus.awid = '0; bus.awlen = 8'd7; bus.awsize = 3'd2; bus.awburst = 2'b01;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    // Valids high during reset must not open the write channel.
    bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_arready", 32'(bus.arready), 32'd1);
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_wready",  32'(bus.wready),  32'd0);
    check("rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("rst_rdata",   bus.rdata,        32'd0);
    check("rst_rresp",   32'(bus.rresp),   32'd0);
    check("rst_bresp",   32'(bus.bresp),   32'd0);
    check("rst_rid",     32'(bus.rid),     32'd0);
    check("rst_bid",     32'(bus.bid),     32'd0);
    check("rlast_const", 32'(bus.rlast),   32'd1);
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Full word write then unaligned read of the same word.
    wr1(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'h3);
    check_lat("w_lat", b_lat);
    check("w_bresp", 32'(b_resp), 32'd0);
    check("w_bid",   32'(b_id),   32'd3);
    rd1(32'h8000_0012, 4'h5);
    check_lat("r_lat", r_lat);
    check("r_data", r_dat,        32'hDEAD_BEEF);
    check("r_resp", 32'(r_resp),  32'd0);
    check("r_id",   32'(r_id),    32'd5);

    // Byte-lane strobes.
    wr1(32'h8000_0004, 32'hFFFF_FFFF, 4'hF, 4'h1);
    wr1(32'h8000_0004, 32'h1234_5678, 4'b0011, 4'h1);
    rd1(32'h8000_0004, 4'h1);
    check("strb_lo", r_dat, 32'hFFFF_5678);
    wr1(32'h8000_0004, 32'h00AB_0000, 4'b0100, 4'h1);
    rd1(32'h8000_0004, 4'h1);
    check("strb_b2", r_dat, 32'hFFAB_5678);
    wr1(32'h8000_0004, 32'h0000_0000, 4'b0000, 4'h6);
    check("strb0_bresp", 32'(b_resp), 32'd0);
    check("strb0_bid",   32'(b_id),   32'd6);
    rd1(32'h8000_0004, 4'h1);
    check("strb0_data", r_dat, 32'hFFAB_5678);

    // Backpressure on the read response.
    issue(1'b1, 32'h8000_0010, 4'h7, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
    n = 0;
    while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid",  32'(bus.rvalid),  32'd1);
      check("bp_rdata",   bus.rdata,        32'hDEAD_BEEF);
      check("bp_arready", 32'(bus.arready), 32'd0);
      @(negedge clk);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check("bp_arready_after", 32'(bus.arready), 32'd1);
    check("bp_rvalid_after",  32'(bus.rvalid),  32'd0);

    // Range boundaries.
    wr1(32'h8000_0000, 32'h1111_1111, 4'hF, 4'h2);
    rd1(32'h8000_1000, 4'h2);
    check("oor_r_resp", 32'(r_resp), 32'd2);
    check("oor_r_data", r_dat,       32'd0);
    wr1(32'h8000_1000, 32'h9999_9999, 4'hF, 4'h2);
    check("oor_w_resp", 32'(b_resp), 32'd2);
    rd1(32'h8000_0000, 4'h2);
    check("oor_no_alias", r_dat, 32'h1111_1111);
    rd1(32'h7FFF_FFFC, 4'h2);
    check("below_base_resp", 32'(r_resp), 32'd2);
    wr1(32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 4'h4);
    check("last_w_resp", 32'(b_resp), 32'd0);
    rd1(32'h8000_0FFC, 4'h4);
    check("last_r_data", r_dat,       32'hCAFE_F00D);
    check("last_r_resp", 32'(r_resp), 32'd0);

    // Same-cycle read and write to one word.
    issue(1'b1, 32'h8000_0020, 4'h8, 1'b1, 32'h8000_0020, 32'hA5A5_A5A5, 4'hF, 4'h9);
    collect(1'b1, 1'b1);
    check("rw_data", r_dat, 32'hA5A5_A5A5);
    check_lat("rw_r_lat", r_lat);
    check_lat("rw_b_lat", b_lat);
    check("rw_bid", 32'(b_id), 32'd9);

    // Asynchronous reset while a read response is pending.
    issue(1'b1, 32'h8000_0010, 4'h2, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
    n = 0;
    while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
    check("arst_pre_rvalid", 32'(bus.rvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_rvalid",  32'(bus.rvalid),  32'd0);
    check("arst_arready", 32'(bus.arready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (bus.rvalid) seen = 1'b1; end
    check("arst_no_late_r", 32'(seen), 32'd0);

    // Reset after a committed write: data stays, response is dropped.
    issue(1'b0, 32'h0, 4'h0, 1'b1, 32'h8000_0030, 32'h0000_0077, 4'hF, 4'h1);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (bus.bvalid) seen = 1'b1; end
    check("arst_no_late_b", 32'(seen), 32'd0);
    rd1(32'h8000_0030, 4'h1);
    check("arst_write_kept", r_dat, 32'h0000_0077);

`ifdef SRAM_RAND_DELAY_EN
    begin
      int lo, hi;
      lo = 99; hi = -1;
      for (int i = 0; i < 100; i++) begin
        rd1(32'h8000_0030, 4'h1);
        if (r_lat < lo) lo = r_lat;
        if (r_lat > hi) hi = r_lat;
      end
      check("rand_min_lat", 32'(lo), 32'd1);
      check("rand_max_lat", 32'(hi), 32'(1 + LAT));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
